mcpu_core_dc_arb: RTL and testbench

- Two-requester arbiter that shares the single data-cache port between the memory stage and the page-table walker (PTW).
- Each requester uses the standard dcache request protocol: the requester holds valid, the arbiter answers with a one-cycle done pulse.
- The arbiter forwards the granted request to the cache and owns it until completion. It also absorbs requests abandoned by a flush, so the cache never sees valid drop mid-transaction.
- Sits between the memory stage / PTW and the dcache.

---
 rtl/mcpu_core_dc_pkg.sv | 29 ++
 rtl/mcpu_core_dc_arb_pick.sv | 26 ++
 rtl/mcpu_core_dc_arb.sv | 149 ++++++++++++++
 tb/tb_mcpu_core_dc_arb.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcpu_core_dc_pkg.sv
// Shared types and constants for the data-cache port arbiter.
// Requester IDs are 0/1 so the round-robin pick is a single bit invert.
package mcpu_core_dc_pkg;

  localparam int DC_PADDR_W = 30;
  localparam int DC_DATA_W  = 32;
  localparam int DC_BE_W    = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_MEM = 2'd1,
    OWN_PTW = 2'd2,
    DRAIN   = 2'd3
  } arb_state_e;

  localparam logic REQ_MEM = 1'b0;
  localparam logic REQ_PTW = 1'b1;

  typedef struct packed {
    logic [DC_PADDR_W-1:0] paddr;
    logic [DC_BE_W-1:0]    write;
    logic [DC_DATA_W-1:0]  data;
  } dc_req_t;

  function automatic arb_state_e own_state(input logic req);
    return (req == REQ_PTW) ? OWN_PTW : OWN_MEM;
  endfunction

endpackage

// File: rtl/mcpu_core_dc_arb_pick.sv
// Combinational 2-way picker: zero latency, no state; caller owns last_grant.
// A lone valid wins; on contention RR favours the non-last requester, else requester 0.
module mcpu_core_dc_arb_pick
  import mcpu_core_dc_pkg::*;
#(
  parameter bit RR_ENABLE = 1'b1
) (
  input  logic mem_vld_i,
  input  logic ptw_vld_i,
  input  logic last_grant_i,
  output logic winner_o,
  output logic any_vld_o
);

  always_comb begin
    winner_o = REQ_MEM;
    if (ptw_vld_i && !mem_vld_i) begin
      winner_o = REQ_PTW;
    end else if (ptw_vld_i && mem_vld_i && RR_ENABLE) begin
      winner_o = ~last_grant_i;
    end
  end

  assign any_vld_o = mem_vld_i | ptw_vld_i;

endmodule

// File: rtl/mcpu_core_dc_arb.sv
// Shares the dcache port between memory stage and PTW; zero-latency forward from IDLE.
// Owner holds the port until arb2dc_done; flushed requests are drained, not dropped.
module mcpu_core_dc_arb
  import mcpu_core_dc_pkg::*;
#(
  parameter bit          RR_ENABLE      = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter int unsigned CNT_W          = 10
) (
  input  logic                  clkrst_core_clk,
  input  logic                  clkrst_core_rst_n,
  input  logic                  mem2arb_valid,
  input  logic [DC_PADDR_W-1:0] mem2arb_paddr,
  input  logic [DC_BE_W-1:0]    mem2arb_write,
  input  logic [DC_DATA_W-1:0]  mem2arb_data_out,
  output logic                  mem2arb_done,
  output logic [DC_DATA_W-1:0]  mem2arb_data_in,
  input  logic                  ptw2arb_valid,
  input  logic [DC_PADDR_W-1:0] ptw2arb_paddr,
  input  logic [DC_BE_W-1:0]    ptw2arb_write,
  input  logic [DC_DATA_W-1:0]  ptw2arb_data_out,
  output logic                  ptw2arb_done,
  output logic [DC_DATA_W-1:0]  ptw2arb_data_in,
  output logic                  arb2dc_valid,
  output logic [DC_PADDR_W-1:0] arb2dc_paddr,
  output logic [DC_BE_W-1:0]    arb2dc_write,
  output logic [DC_DATA_W-1:0]  arb2dc_data_out,
  input  logic                  arb2dc_done,
  input  logic [DC_DATA_W-1:0]  arb2dc_data_in,
  output logic                  arb_busy,
  output logic                  arb_timeout
);

  localparam bit             WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES);

  arb_state_e       state_q, state_d;
  logic             last_q, last_d;
  dc_req_t          hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  dc_req_t mem_req, ptw_req, win_req, dc_req;
  logic    win, any_vld;
  logic    dc_vld, mem_done, ptw_done;

  assign mem_req = {mem2arb_paddr, mem2arb_write, mem2arb_data_out};
  assign ptw_req = {ptw2arb_paddr, ptw2arb_write, ptw2arb_data_out};
  assign win_req = (win == REQ_PTW) ? ptw_req : mem_req;

  mcpu_core_dc_arb_pick #(.RR_ENABLE(RR_ENABLE)) u_pick (
    .mem_vld_i    (mem2arb_valid),
    .ptw_vld_i    (ptw2arb_valid),
    .last_grant_i (last_q),
    .winner_o     (win),
    .any_vld_o    (any_vld)
  );

  // last_grant is only consulted in IDLE, so recording it at grant time is
  // equivalent to recording it on completion and spares an owner register.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    hold_d   = hold_q;
    dc_vld   = 1'b0;
    dc_req   = hold_q;
    mem_done = 1'b0;
    ptw_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_vld) begin
          dc_vld = 1'b1;
          dc_req = win_req;
          hold_d = win_req;
          last_d = win;
          if (arb2dc_done) begin
            mem_done = (win == REQ_MEM);
            ptw_done = (win == REQ_PTW);
          end else begin
            state_d = own_state(win);
          end
        end
      end
      OWN_MEM: begin
        dc_vld = 1'b1;
        if (arb2dc_done) begin
          mem_done = mem2arb_valid;
          state_d  = IDLE;
        end else if (!mem2arb_valid) begin
          state_d = DRAIN;
        end
      end
      OWN_PTW: begin
        dc_vld = 1'b1;
        if (arb2dc_done) begin
          ptw_done = ptw2arb_valid;
          state_d  = IDLE;
        end else if (!ptw2arb_valid) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        dc_vld = 1'b1;
        if (arb2dc_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (arb2dc_done) begin
      cnt_d = '0;
    end else if ((state_q != IDLE) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign timeout_d = timeout_q | (WD_EN && (cnt_d == CNT_LIM));

  always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
    if (!clkrst_core_rst_n) begin
      state_q   <= IDLE;
      last_q    <= REQ_PTW;
      hold_q    <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // IDLE forwarding is combinational from the requesters, so reset must gate it.
  assign arb2dc_valid = dc_vld & clkrst_core_rst_n;
  assign {arb2dc_paddr, arb2dc_write, arb2dc_data_out} = dc_req;
  assign mem2arb_done    = mem_done & clkrst_core_rst_n;
  assign ptw2arb_done    = ptw_done & clkrst_core_rst_n;
  assign mem2arb_data_in = arb2dc_data_in;
  assign ptw2arb_data_in = arb2dc_data_in;
  assign arb_busy        = (state_q != IDLE);
  assign arb_timeout     = timeout_q;

endmodule

// File: tb/tb_mcpu_core_dc_arb.sv
// Bench: instance 0 is round-robin with an 8-cycle watchdog, instance 1 fixed-priority, watchdog off.
module tb_mcpu_core_dc_arb;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        m_v[2], p_v[2], d_done[2];
  logic [29:0] m_pa[2], p_pa[2];
  logic [3:0]  m_wr[2], p_wr[2];
  logic [31:0] m_do[2], p_do[2], d_di[2];
  logic        m_done[2], p_done[2], dc_v[2], busy[2], tmo[2];
  logic [31:0] m_di[2], p_di[2], dc_do[2];
  logic [29:0] dc_pa[2];
  logic [3:0]  dc_wr[2];

  int ncmp = 0;
  int nfail = 0;

  localparam logic [29:0] PM = 30'h40;
  localparam logic [29:0] PP = 30'h80;

  mcpu_core_dc_arb #(.RR_ENABLE(1'b1), .TIMEOUT_CYCLES(8), .CNT_W(4)) dut (
    .clkrst_core_clk(clk), .clkrst_core_rst_n(rst_n),
    .mem2arb_valid(m_v[0]), .mem2arb_paddr(m_pa[0]), .mem2arb_write(m_wr[0]),
    .mem2arb_data_out(m_do[0]), .mem2arb_done(m_done[0]), .mem2arb_data_in(m_di[0]),
    .ptw2arb_valid(p_v[0]), .ptw2arb_paddr(p_pa[0]), .ptw2arb_write(p_wr[0]),
    .ptw2arb_data_out(p_do[0]), .ptw2arb_done(p_done[0]), .ptw2arb_data_in(p_di[0]),
    .arb2dc_valid(dc_v[0]), .arb2dc_paddr(dc_pa[0]), .arb2dc_write(dc_wr[0]),
    .arb2dc_data_out(dc_do[0]), .arb2dc_done(d_done[0]), .arb2dc_data_in(d_di[0]),
    .arb_busy(busy[0]), .arb_timeout(tmo[0])
  );

  mcpu_core_dc_arb #(.RR_ENABLE(1'b0), .TIMEOUT_CYCLES(0), .CNT_W(4)) dut_fp (
    .clkrst_core_clk(clk), .clkrst_core_rst_n(rst_n),
    .mem2arb_valid(m_v[1]), .mem2arb_paddr(m_pa[1]), .mem2arb_write(m_wr[1]),
    .mem2arb_data_out(m_do[1]), .mem2arb_done(m_done[1]), .mem2arb_data_in(m_di[1]),
    .ptw2arb_valid(p_v[1]), .ptw2arb_paddr(p_pa[1]), .ptw2arb_write(p_wr[1]),
    .ptw2arb_data_out(p_do[1]), .ptw2arb_done(p_done[1]), .ptw2arb_data_in(p_di[1]),
    .arb2dc_valid(dc_v[1]), .arb2dc_paddr(dc_pa[1]), .arb2dc_write(dc_wr[1]),
    .arb2dc_data_out(dc_do[1]), .arb2dc_done(d_done[1]), .arb2dc_data_in(d_di[1]),
    .arb_busy(busy[1]), .arb_timeout(tmo[1])
  );

  typedef struct packed {
    logic             mv, pv, dn;
    logic [1:0]       ev, emd, epd, eb;
    logic [1:0][29:0] epa;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(input logic mv, pv, dn, input logic [1:0] ev, emd, epd, eb,
                              input logic [29:0] pa0, pa1);
    vec_t v;
    v.mv = mv; v.pv = pv; v.dn = dn;
    v.ev = ev; v.emd = emd; v.epd = epd; v.eb = eb;
    v.epa[0] = pa0; v.epa[1] = pa1;
    return v;
  endfunction

  task automatic chk1(input string nm, input logic a, input logic e);
    ncmp++;
    if (a !== e) begin
      nfail++;
      $display("FAIL %s: got %b want %b at %0t", nm, a, e, $time);
    end
  endtask

  task automatic chkv(input string nm, input logic [65:0] a, input logic [65:0] e);
    ncmp++;
    if (a !== e) begin
      nfail++;
      $display("FAIL %s: got %h want %h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic chk_dc0(input string nm, input logic [29:0] pa, input logic [3:0] wr,
                         input logic [31:0] d);
    chk1(nm, dc_v[0], 1'b1);
    chkv(nm, {dc_pa[0], dc_wr[0], dc_do[0]}, {pa, wr, d});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    for (int k = 0; k < 2; k++) begin
      m_v[k] = 1'b0; p_v[k] = 1'b0; d_done[k] = 1'b0;
      m_pa[k] = '0; p_pa[k] = '0; m_wr[k] = '0; p_wr[k] = '0;
      m_do[k] = '0; p_do[k] = '0; d_di[k] = '0;
    end
  endtask

  // Transaction-level reference: who holds the port, what they asked for, whether they bailed.
  int          own[2], lastg[2], cnt[2];
  bit          aband[2], tmo_e[2], md_prev[2], pd_prev[2];
  logic [65:0] held[2];

  task automatic model_check(input int k);
    logic [65:0] mreq, preq, ereq;
    bit ev, emd, epd, ebusy, ov;
    int w, lim;
    lim   = (k == 0) ? 8 : 0;
    mreq  = {m_pa[k], m_wr[k], m_do[k]};
    preq  = {p_pa[k], p_wr[k], p_do[k]};
    ebusy = (own[k] >= 0);
    ev = 0; emd = 0; epd = 0; ereq = '0;
    if (own[k] < 0) begin
      if (m_v[k] || p_v[k]) begin
        if (m_v[k] && p_v[k]) w = (k == 0) ? 1 - lastg[k] : 0;
        else                  w = p_v[k] ? 1 : 0;
        ev   = 1;
        ereq = (w == 1) ? preq : mreq;
        if (d_done[k]) begin
          emd = (w == 0); epd = (w == 1); lastg[k] = w;
        end else begin
          own[k] = w; held[k] = ereq; aband[k] = 0;
        end
      end
    end else begin
      ev   = 1;
      ereq = held[k];
      ov   = (own[k] == 0) ? m_v[k] : p_v[k];
      if (!ov) aband[k] = 1;
      if (d_done[k]) begin
        emd = (own[k] == 0) && !aband[k];
        epd = (own[k] == 1) && !aband[k];
        lastg[k] = own[k];
        own[k] = -1;
      end
    end
    chk1("rnd_valid", dc_v[k], ev);
    if (ev) chkv("rnd_req", {dc_pa[k], dc_wr[k], dc_do[k]}, ereq);
    chk1("rnd_mem_done", m_done[k], emd);
    chk1("rnd_ptw_done", p_done[k], epd);
    chk1("rnd_busy", busy[k], ebusy);
    chk1("rnd_timeout", tmo[k], tmo_e[k]);
    chkv("rnd_rdata", 66'({m_di[k], p_di[k]}), 66'({d_di[k], d_di[k]}));
    md_prev[k] = emd;
    pd_prev[k] = epd;
    if (d_done[k]) cnt[k] = 0;
    else if (ebusy) cnt[k] = (cnt[k] < 15) ? cnt[k] + 1 : 15;
    if (lim != 0 && cnt[k] >= lim) tmo_e[k] = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    tbl[0]  = mk(0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, PM, PM);
    tbl[1]  = mk(1, 0, 1, 2'b11, 2'b11, 2'b00, 2'b00, PM, PM);
    tbl[2]  = mk(0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, PM, PM);
    tbl[3]  = mk(1, 1, 0, 2'b11, 2'b00, 2'b00, 2'b00, PP, PM);
    tbl[4]  = mk(1, 1, 0, 2'b11, 2'b00, 2'b00, 2'b11, PP, PM);
    tbl[5]  = mk(1, 1, 1, 2'b11, 2'b10, 2'b01, 2'b11, PP, PM);
    tbl[6]  = mk(1, 1, 0, 2'b11, 2'b00, 2'b00, 2'b00, PM, PM);
    tbl[7]  = mk(1, 1, 0, 2'b11, 2'b00, 2'b00, 2'b11, PM, PM);
    tbl[8]  = mk(1, 1, 1, 2'b11, 2'b11, 2'b00, 2'b11, PM, PM);
    tbl[9]  = mk(1, 1, 0, 2'b11, 2'b00, 2'b00, 2'b00, PP, PM);
    tbl[10] = mk(1, 1, 1, 2'b11, 2'b10, 2'b01, 2'b11, PP, PM);
    tbl[11] = mk(0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, PM, PM);
    tbl[12] = mk(0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, PM, PM);

    // Reset with requests and a cache done pending: nothing may leak out.
    clear_in();
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin m_v[k] = 1'b1; d_done[k] = 1'b1; end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk1("reset_valid", dc_v[k], 1'b0);
      chk1("reset_done", m_done[k], 1'b0);
      chk1("reset_busy", busy[k], 1'b0);
      chk1("reset_timeout", tmo[k], 1'b0);
    end
    tick();
    clear_in();
    rst_n = 1'b1;

    for (int r = 0; r < 13; r++) begin
      for (int k = 0; k < 2; k++) begin
        m_v[k] = tbl[r].mv; p_v[k] = tbl[r].pv; d_done[k] = tbl[r].dn;
        m_pa[k] = PM; p_pa[k] = PP; d_di[k] = 32'hDEADBEEF;
      end
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk1("tbl_valid", dc_v[k], tbl[r].ev[k]);
        if (tbl[r].ev[k]) chkv("tbl_paddr", 66'(dc_pa[k]), 66'(tbl[r].epa[k]));
        chk1("tbl_mem_done", m_done[k], tbl[r].emd[k]);
        chk1("tbl_ptw_done", p_done[k], tbl[r].epd[k]);
        chk1("tbl_busy", busy[k], tbl[r].eb[k]);
        chkv("tbl_rdata", 66'(m_di[k]), 66'(32'hDEADBEEF));
      end
      tick();
    end
    clear_in();

    // Flush: memory write abandoned in cycle 2, cache completes in cycle 5.
    m_v[0] = 1'b1; m_pa[0] = 30'h100; m_wr[0] = 4'h3; m_do[0] = 32'h12345678;
    @(negedge clk);
    chk_dc0("flush_fwd", 30'h100, 4'h3, 32'h12345678);
    tick();
    for (int c = 2; c <= 5; c++) begin
      m_v[0] = (c == 4 || c == 5);
      m_pa[0] = 30'h3FF; m_do[0] = 32'h0;
      p_v[0] = 1'b1; p_pa[0] = 30'h200;
      d_done[0] = (c == 5);
      @(negedge clk);
      chk_dc0("flush_hold", 30'h100, 4'h3, 32'h12345678);
      chk1("flush_mem_done", m_done[0], 1'b0);
      chk1("flush_ptw_done", p_done[0], 1'b0);
      chk1("flush_busy", busy[0], 1'b1);
      tick();
    end
    d_done[0] = 1'b0;
    @(negedge clk);
    chk_dc0("flush_next_grant", 30'h200, 4'h0, 32'h0);
    chk1("flush_next_busy", busy[0], 1'b0);
    tick();
    d_done[0] = 1'b1;
    @(negedge clk);
    chk1("flush_ptw_done2", p_done[0], 1'b1);
    chk1("flush_mem_done2", m_done[0], 1'b0);
    tick();
    clear_in();
    @(negedge clk);
    tick();

    // PTW request changes its address while owning the port; no done for 9 cycles.
    p_v[0] = 1'b1; p_pa[0] = 30'h300;
    @(negedge clk);
    chk_dc0("wd_grant", 30'h300, 4'h0, 32'h0);
    tick();
    for (int c = 1; c <= 8; c++) begin
      p_pa[0] = 30'h300 + 30'(c);
      @(negedge clk);
      chk_dc0("stable_paddr", 30'h300, 4'h0, 32'h0);
      chk1("wd_not_yet", tmo[0], 1'b0);
      tick();
    end
    d_done[0] = 1'b1;
    @(negedge clk);
    chk1("wd_set", tmo[0], 1'b1);
    chk_dc0("stable_at_done", 30'h300, 4'h0, 32'h0);
    chk1("wd_ptw_done", p_done[0], 1'b1);
    chk1("wd_fp_off", tmo[1], 1'b0);
    tick();
    clear_in();
    @(negedge clk);
    chk1("wd_sticky", tmo[0], 1'b1);
    chk1("wd_idle", busy[0], 1'b0);
    tick();

    // Asynchronous reset while the memory stage owns the port.
    m_v[0] = 1'b1; m_pa[0] = PM;
    @(negedge clk);
    tick();
    chk1("own_mem_busy", busy[0], 1'b1);
    d_done[0] = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk1("rst_mid_valid", dc_v[0], 1'b0);
    chk1("rst_mid_busy", busy[0], 1'b0);
    chk1("rst_mid_done", m_done[0], 1'b0);
    chk1("rst_mid_timeout", tmo[0], 1'b0);
    tick();
    d_done[0] = 1'b0; p_v[0] = 1'b1; p_pa[0] = PP;
    rst_n = 1'b1;
    @(negedge clk);
    chkv("rst_first_contention", 66'(dc_pa[0]), 66'(PM));
    tick();
    d_done[0] = 1'b1;
    @(negedge clk);
    chk1("rst_mem_done", m_done[0], 1'b1);
    chk1("rst_ptw_done", p_done[0], 1'b0);
    tick();
    clear_in();

    // Randomized traffic against the transaction-level model.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      own[k] = -1; lastg[k] = 1; cnt[k] = 0; aband[k] = 0; tmo_e[k] = 0;
      held[k] = '0; md_prev[k] = 0; pd_prev[k] = 0;
    end
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int k = 0; k < 2; k++) begin
        if (m_v[k] && !md_prev[k]) begin
          if ($urandom_range(15) == 0) m_v[k] = 1'b0;
        end else m_v[k] = ($urandom_range(2) != 0);
        if (p_v[k] && !pd_prev[k]) begin
          if ($urandom_range(15) == 0) p_v[k] = 1'b0;
        end else p_v[k] = ($urandom_range(2) != 0);
        if ($urandom_range(3) == 0) begin
          m_pa[k] = 30'($urandom); m_wr[k] = 4'($urandom); m_do[k] = $urandom;
        end
        if ($urandom_range(3) == 0) begin
          p_pa[k] = 30'($urandom); p_wr[k] = 4'($urandom); p_do[k] = $urandom;
        end
        d_done[k] = ($urandom_range((cyc < 400) ? 2 : 9) == 0);
        d_di[k] = $urandom;
      end
      @(negedge clk);
      for (int k = 0; k < 2; k++) model_check(k);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
